// File: rtl/key_extract_pkg.sv
// Shared widths, field positions and encodings for the key extractor.
// The config word is {six 3b offsets, 20b comparator, KEY_LEN-bit mask}.
package key_extract_pkg;

    localparam int W6     = 48;
    localparam int W4     = 32;
    localparam int W2     = 16;
    localparam int META_W = 256;

    localparam int KEY_LEN = 2 * W6 + 2 * W4 + 2 * W2 + 1;
    localparam int OFF_W   = 3;
    localparam int OFFS_W  = 6 * OFF_W;
    localparam int CMP_W   = 20;
    localparam int CFG_W   = OFFS_W + CMP_W + KEY_LEN;

    localparam int CFG_CMP_LSB = KEY_LEN;

    // Comparator sub-fields; a non-immediate operand uses its low SRC_W bits as {type, index}
    localparam int CMP_OP_MSB   = 19;
    localparam int CMP_IMM1     = 17;
    localparam int CMP_OPD1_MSB = 16;
    localparam int CMP_IMM2     = 8;
    localparam int CMP_OPD2_MSB = 7;
    localparam int SRC_W        = 5;

    typedef enum logic [1:0] {
        OP_GT   = 2'b00,
        OP_GE   = 2'b01,
        OP_EQ   = 2'b10,
        OP_TRUE = 2'b11
    } cmp_op_e;

    typedef enum logic [1:0] {
        SRC_2B   = 2'b00,
        SRC_4B   = 2'b01,
        SRC_6B   = 2'b10,
        SRC_ZERO = 2'b11
    } src_type_e;

    function automatic int phv_len(input int c6, input int c4, input int c2);
        return W6 * c6 + W4 * c4 + W2 * c2 + META_W;
    endfunction

endpackage

// File: rtl/key_extract_mt_cmp.sv
// Condition-bit evaluator: picks two 8-bit operands (immediate or container
// low byte) and compares them unsigned according to the opcode.
module key_cmp_unit
    import key_extract_pkg::*;
#(
    parameter int C6_NUM = 8,
    parameter int C4_NUM = 8,
    parameter int C2_NUM = 8
) (
    input  logic [C6_NUM-1:0][7:0] lo6,
    input  logic [C4_NUM-1:0][7:0] lo4,
    input  logic [C2_NUM-1:0][7:0] lo2,
    input  logic [CMP_W-1:0]       cmp,
    output logic                   cond
);

    function automatic logic [7:0] pick(input logic [SRC_W-1:0] sel);
        logic [7:0] v;
        v = '0;
        case (src_type_e'(sel[4:3]))
            SRC_6B: for (int i = 0; i < C6_NUM; i++) if (sel[2:0] == 3'(i)) v = lo6[i];
            SRC_4B: for (int i = 0; i < C4_NUM; i++) if (sel[2:0] == 3'(i)) v = lo4[i];
            SRC_2B: for (int i = 0; i < C2_NUM; i++) if (sel[2:0] == 3'(i)) v = lo2[i];
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [7:0] opd_a;
    logic [7:0] opd_b;

    always_comb begin
        opd_a = cmp[CMP_IMM1] ? cmp[CMP_OPD1_MSB -: 8] : pick(cmp[CMP_OPD1_MSB-3 -: SRC_W]);
        opd_b = cmp[CMP_IMM2] ? cmp[CMP_OPD2_MSB -: 8] : pick(cmp[CMP_OPD2_MSB-3 -: SRC_W]);
        case (cmp_op_e'(cmp[CMP_OP_MSB -: 2]))
            OP_GT:   cond = (opd_a > opd_b);
            OP_GE:   cond = (opd_a >= opd_b);
            OP_EQ:   cond = (opd_a == opd_b);
            default: cond = 1'b1;
        endcase
    end

endmodule

// File: rtl/key_extract_mt.sv
// Two-stage per-tenant key extractor: S1 holds the PHV and tenant ID, S2 holds
// the PHV plus the masked key built from the tenant's config entry.
module key_extract_mt
    import key_extract_pkg::*;
#(
    parameter int  C6_NUM    = 8,
    parameter int  C4_NUM    = 8,
    parameter int  C2_NUM    = 8,
    parameter int  CFG_DEPTH = 16,
    parameter int  VID_MSB   = 140,
    localparam int PHV_LEN   = phv_len(C6_NUM, C4_NUM, C2_NUM),
    localparam int VID_W     = $clog2(CFG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    output logic               phv_ready_out,
    output logic [PHV_LEN-1:0] phv_out,
    output logic [KEY_LEN-1:0] key_out,
    output logic               phv_valid_out,
    input  logic               phv_ready_in,
    input  logic               cfg_wr_en,
    input  logic [VID_W-1:0]   cfg_addr,
    input  logic [CFG_W-1:0]   cfg_data
);

    localparam int BASE4 = PHV_LEN - W6 * C6_NUM;
    localparam int BASE2 = BASE4 - W4 * C4_NUM;

    logic               s1_valid;
    logic [PHV_LEN-1:0] s1_phv;
    logic [VID_W-1:0]   s1_vid;
    logic               s2_free;

    logic [CFG_W-1:0]   cfg_mem [CFG_DEPTH];
    logic [CFG_W-1:0]   entry;
    logic [OFF_W-1:0]   off [6];

    logic [W6-1:0] c6 [C6_NUM];
    logic [W4-1:0] c4 [C4_NUM];
    logic [W2-1:0] c2 [C2_NUM];
    logic [C6_NUM-1:0][7:0] lo6;
    logic [C4_NUM-1:0][7:0] lo4;
    logic [C2_NUM-1:0][7:0] lo2;

    logic [W6-1:0] f6a, f6b;
    logic [W4-1:0] f4a, f4b;
    logic [W2-1:0] f2a, f2b;
    logic          cond;
    logic [KEY_LEN-1:0] key_next;

    // Ready depends only on registered state and the downstream ready
    assign s2_free       = ~phv_valid_out | phv_ready_in;
    assign phv_ready_out = ~s1_valid | s2_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_phv   <= '0;
            s1_vid   <= '0;
        end else if (phv_ready_out) begin
            s1_valid <= phv_valid_in;
            if (phv_valid_in) begin
                s1_phv <= phv_in;
                s1_vid <= phv_in[VID_MSB -: VID_W];
            end
        end
    end

    // Same-cycle write and read of one entry: the read sees the pre-write value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CFG_DEPTH; i++) cfg_mem[i] <= '0;
        end else if (cfg_wr_en) begin
            cfg_mem[cfg_addr] <= cfg_data;
        end
    end

    assign entry = cfg_mem[s1_vid];

    for (genvar k = 0; k < 6; k++) begin : g_off
        assign off[k] = entry[CFG_W-1-OFF_W*k -: OFF_W];
    end

    for (genvar i = 0; i < C6_NUM; i++) begin : g_c6
        assign c6[i]  = s1_phv[PHV_LEN-1-W6*i -: W6];
        assign lo6[i] = c6[i][7:0];
    end
    for (genvar i = 0; i < C4_NUM; i++) begin : g_c4
        assign c4[i]  = s1_phv[BASE4-1-W4*i -: W4];
        assign lo4[i] = c4[i][7:0];
    end
    for (genvar i = 0; i < C2_NUM; i++) begin : g_c2
        assign c2[i]  = s1_phv[BASE2-1-W2*i -: W2];
        assign lo2[i] = c2[i][7:0];
    end

    // Offsets beyond the container count match no index and leave the field zero
    always_comb begin
        f6a = '0;
        f6b = '0;
        f4a = '0;
        f4b = '0;
        f2a = '0;
        f2b = '0;
        for (int i = 0; i < C6_NUM; i++) begin
            if (off[0] == OFF_W'(i)) f6a = c6[i];
            if (off[1] == OFF_W'(i)) f6b = c6[i];
        end
        for (int i = 0; i < C4_NUM; i++) begin
            if (off[2] == OFF_W'(i)) f4a = c4[i];
            if (off[3] == OFF_W'(i)) f4b = c4[i];
        end
        for (int i = 0; i < C2_NUM; i++) begin
            if (off[4] == OFF_W'(i)) f2a = c2[i];
            if (off[5] == OFF_W'(i)) f2b = c2[i];
        end
    end

    key_cmp_unit #(
        .C6_NUM(C6_NUM),
        .C4_NUM(C4_NUM),
        .C2_NUM(C2_NUM)
    ) u_cmp (
        .lo6 (lo6),
        .lo4 (lo4),
        .lo2 (lo2),
        .cmp (entry[CFG_CMP_LSB +: CMP_W]),
        .cond(cond)
    );

    assign key_next = {f6a, f6b, f4a, f4b, f2a, f2b, cond} & entry[KEY_LEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phv_valid_out <= 1'b0;
            phv_out       <= '0;
            key_out       <= '0;
        end else if (s2_free) begin
            phv_valid_out <= s1_valid;
            if (s1_valid) begin
                phv_out <= s1_phv;
                key_out <= key_next;
            end
        end
    end

endmodule

// File: tb/tb_key_extract_mt.sv
// Scoreboard bench for key_extract_mt with four 6B containers so that
// out-of-range 6B offsets can be exercised.
module tb_key_extract_mt;

    localparam int C6   = 4;
    localparam int C4   = 8;
    localparam int C2   = 8;
    localparam int PL   = 48 * C6 + 32 * C4 + 16 * C2 + 256;
    localparam int KL   = 193;
    localparam int CW   = 18 + 20 + KL;
    localparam int VW   = 4;
    localparam int VMSB = 140;

    logic          clk = 1'b0;
    logic          rst;
    logic [PL-1:0] phv_in;
    logic          phv_valid_in;
    logic          phv_ready_out;
    logic [PL-1:0] phv_out;
    logic [KL-1:0] key_out;
    logic          phv_valid_out;
    logic          phv_ready_in;
    logic          cfg_wr_en;
    logic [VW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;

    key_extract_mt #(
        .C6_NUM(C6), .C4_NUM(C4), .C2_NUM(C2), .CFG_DEPTH(16), .VID_MSB(VMSB)
    ) dut (
        .clk(clk), .rst(rst), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .phv_ready_out(phv_ready_out), .phv_out(phv_out), .key_out(key_out),
        .phv_valid_out(phv_valid_out), .phv_ready_in(phv_ready_in),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] shadow [16];
    logic [KL-1:0] exp_key_q [$];
    logic [PL-1:0] exp_phv_q [$];

    logic          got_in, got_out, got_vout;
    logic [KL-1:0] got_key;
    logic [PL-1:0] got_phv;

    // ---------------- reference model ----------------
    function automatic logic [47:0] m6(input logic [PL-1:0] p, input int i);
        logic [PL-1:0] t;
        if (i >= C6) return '0;
        t = p >> (PL - 48 * (i + 1));
        return t[47:0];
    endfunction

    function automatic logic [31:0] m4(input logic [PL-1:0] p, input int i);
        logic [PL-1:0] t;
        if (i >= C4) return '0;
        t = p >> (PL - 48 * C6 - 32 * (i + 1));
        return t[31:0];
    endfunction

    function automatic logic [15:0] m2(input logic [PL-1:0] p, input int i);
        logic [PL-1:0] t;
        if (i >= C2) return '0;
        t = p >> (PL - 48 * C6 - 32 * C4 - 16 * (i + 1));
        return t[15:0];
    endfunction

    function automatic logic [7:0] mbyte(input logic [PL-1:0] p, input logic [4:0] s);
        logic [47:0] t6;
        logic [31:0] t4;
        logic [15:0] t2;
        t6 = m6(p, int'(s[2:0]));
        t4 = m4(p, int'(s[2:0]));
        t2 = m2(p, int'(s[2:0]));
        case (s[4:3])
            2'b10:   return t6[7:0];
            2'b01:   return t4[7:0];
            2'b00:   return t2[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [KL-1:0] model(input logic [PL-1:0] p, input logic [CW-1:0] cfg);
        logic [17:0]   o;
        logic [19:0]   c;
        logic [7:0]    a, b;
        logic          cnd;
        logic [KL-2:0] fields;
        o = cfg[CW-1 -: 18];
        c = cfg[KL +: 20];
        fields = {m6(p, int'(o[17:15])), m6(p, int'(o[14:12])), m4(p, int'(o[11:9])),
                  m4(p, int'(o[8:6])), m2(p, int'(o[5:3])), m2(p, int'(o[2:0]))};
        a = c[17] ? c[16:9] : mbyte(p, c[13:9]);
        b = c[8]  ? c[7:0]  : mbyte(p, c[4:0]);
        case (c[19:18])
            2'b00:   cnd = (a > b);
            2'b01:   cnd = (a >= b);
            2'b10:   cnd = (a == b);
            default: cnd = 1'b1;
        endcase
        return {fields, cnd} & cfg[KL-1:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [CW-1:0] mk_cfg(input int o0, input int o1, input int o2, input int o3,
                                             input int o4, input int o5, input logic [19:0] c,
                                             input logic [KL-1:0] m);
        return {3'(o0), 3'(o1), 3'(o2), 3'(o3), 3'(o4), 3'(o5), c, m};
    endfunction

    function automatic logic [PL-1:0] rand_phv(input int vid);
        logic [PL-1:0] p;
        for (int i = 0; i < PL / 32; i++) p[i*32 +: 32] = $urandom();
        p[VMSB -: VW] = 4'(vid);
        return p;
    endfunction

    function automatic logic [PL-1:0] set_c2lo(input logic [PL-1:0] p, input int idx, input logic [7:0] v);
        p[PL - 48*C6 - 32*C4 - 16*(idx+1) +: 8] = v;
        return p;
    endfunction

    function automatic logic [PL-1:0] set_c4lo(input logic [PL-1:0] p, input int idx, input logic [7:0] v);
        p[PL - 48*C6 - 32*(idx+1) +: 8] = v;
        return p;
    endfunction

    // One clock: sample handshakes, record writes and accepted PHVs, advance
    task automatic step();
        #2;
        got_in   = phv_valid_in && phv_ready_out;
        got_out  = phv_valid_out && phv_ready_in;
        got_vout = phv_valid_out;
        got_key  = key_out;
        got_phv  = phv_out;
        if (cfg_wr_en) shadow[cfg_addr] = cfg_data;
        if (got_in) begin
            exp_key_q.push_back(model(phv_in, shadow[phv_in[VMSB -: VW]]));
            exp_phv_q.push_back(phv_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input int addr, input logic [CW-1:0] data);
        cfg_wr_en = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_data  = data;
        step();
        cfg_wr_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [KL-1:0] ek;
        logic [PL-1:0] ep;
        int n_out;
        total++; if (phv_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b exp=0", phv_valid_out); end
        total++; if (key_out !== '0) begin bad++; $display("FAIL reset_key: got=%h exp=0", key_out); end
        total++; if (phv_out !== '0) begin bad++; $display("FAIL reset_phv: got nonzero exp=0"); end
        rst = 1'b0;
        #1;
        total++; if (phv_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b exp=1", phv_ready_out); end
        // Zeroed table gives an all-zero key
        phv_ready_in = 1'b1;
        phv_valid_in = 1'b1;
        phv_in = rand_phv(9);
        step();
        phv_valid_in = 1'b0;
        n_out = 0;
        for (int c = 0; c < 10 && n_out < 1; c++) begin
            step();
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== '0 || got_key !== ek || got_phv !== ep) begin
                    bad++; $display("FAIL reset_table_key: got=%h exp=%h", got_key, ek);
                end
                n_out++;
            end
        end
        total++; if (n_out != 1) begin bad++; $display("FAIL reset_table_timeout: got=%0d exp=1", n_out); end
    endtask

    task automatic test_extract();
        logic [KL-1:0] ek;
        logic [PL-1:0] ep;
        int n_out, lat;
        wr_cfg(3, mk_cfg(1, 0, 2, 7, 0, 5, {2'b11, 18'h0}, '1));
        wr_cfg(9, mk_cfg(7, 4, 7, 3, 7, 1, {2'b11, 18'h0}, '1));
        phv_ready_in = 1'b1;
        phv_valid_in = 1'b1;
        phv_in = rand_phv(3);
        step();
        phv_in = rand_phv(9);
        step();
        phv_valid_in = 1'b0;
        n_out = 0;
        lat = 1;
        for (int c = 0; c < 12 && n_out < 2; c++) begin
            step();
            lat++;
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== ek || got_phv !== ep) begin
                    bad++; $display("FAIL extract_key: got=%h exp=%h phv_ok=%0d", got_key, ek, got_phv === ep);
                end
                if (n_out == 0) begin
                    total++;
                    if (lat != 2) begin bad++; $display("FAIL extract_latency: got=%0d exp=2", lat); end
                    total++;
                    if (got_key[0] !== 1'b1) begin bad++; $display("FAIL extract_cond: got=%b exp=1", got_key[0]); end
                end else begin
                    total++;
                    if (got_key[192:97] !== '0) begin
                        bad++; $display("FAIL extract_oob_zero: got=%h exp=0", got_key[192:97]);
                    end
                end
                n_out++;
            end
        end
        total++; if (n_out != 2) begin bad++; $display("FAIL extract_timeout: got=%0d exp=2", n_out); end
    endtask

    task automatic test_compare();
        logic [PL-1:0] stim [5];
        logic          exp_cond [5];
        logic [KL-1:0] ek;
        logic [PL-1:0] ep;
        int n_in, n_out;
        wr_cfg(6, mk_cfg(0, 0, 0, 0, 0, 0, {2'b00, 1'b1, 8'h10, 1'b0, 8'h02}, '1));
        wr_cfg(7, mk_cfg(0, 0, 0, 0, 0, 0, {2'b01, 1'b1, 8'h10, 1'b0, 8'h02}, '1));
        wr_cfg(8, mk_cfg(1, 1, 1, 1, 1, 1, {2'b10, 1'b1, 8'h5A, 1'b0, 8'h0B}, 193'h1));
        stim[0] = set_c2lo(rand_phv(6), 2, 8'h0F); exp_cond[0] = 1'b1;
        stim[1] = set_c2lo(rand_phv(6), 2, 8'h10); exp_cond[1] = 1'b0;
        stim[2] = set_c2lo(rand_phv(7), 2, 8'h10); exp_cond[2] = 1'b1;
        stim[3] = set_c4lo(rand_phv(8), 3, 8'h5A); exp_cond[3] = 1'b1;
        stim[4] = set_c4lo(rand_phv(8), 3, 8'h5B); exp_cond[4] = 1'b0;
        phv_ready_in = 1'b1;
        n_in = 0;
        n_out = 0;
        for (int c = 0; c < 20 && n_out < 5; c++) begin
            phv_valid_in = (n_in < 5);
            phv_in = stim[n_in < 5 ? n_in : 4];
            step();
            if (got_in) n_in++;
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== ek || got_phv !== ep) begin
                    bad++; $display("FAIL compare_key%0d: got=%h exp=%h", n_out, got_key, ek);
                end
                total++;
                if (got_key[0] !== exp_cond[n_out]) begin
                    bad++; $display("FAIL compare_cond%0d: got=%b exp=%b", n_out, got_key[0], exp_cond[n_out]);
                end
                if (n_out >= 3) begin
                    total++;
                    if (got_key !== {192'b0, exp_cond[n_out]}) begin
                        bad++; $display("FAIL compare_mask%0d: got=%h exp=%0d", n_out, got_key, exp_cond[n_out]);
                    end
                end
                n_out++;
            end
        end
        phv_valid_in = 1'b0;
        total++; if (n_out != 5) begin bad++; $display("FAIL compare_timeout: got=%0d exp=5", n_out); end
    endtask

    task automatic test_backpressure();
        logic [PL-1:0] stim [4];
        logic [KL-1:0] ek, ref_key;
        logic [PL-1:0] ep, ref_phv;
        logic have_ref;
        int n_in, n_out;
        for (int i = 0; i < 4; i++) stim[i] = rand_phv(3);
        phv_ready_in = 1'b0;
        n_in = 0;
        have_ref = 1'b0;
        for (int c = 0; c < 5; c++) begin
            phv_valid_in = 1'b1;
            phv_in = stim[n_in];
            step();
            if (got_in) n_in++;
            if (got_vout && have_ref) begin
                total++;
                if (got_key !== ref_key || got_phv !== ref_phv) begin
                    bad++; $display("FAIL bp_stable: got=%h exp=%h", got_key, ref_key);
                end
            end
            if (got_vout && !have_ref) begin
                ref_key = got_key; ref_phv = got_phv; have_ref = 1'b1;
            end
        end
        total++; if (n_in != 2) begin bad++; $display("FAIL bp_accepted: got=%0d exp=2", n_in); end
        total++; if (phv_ready_out !== 1'b0) begin bad++; $display("FAIL bp_ready: got=%b exp=0", phv_ready_out); end
        phv_ready_in = 1'b1;
        n_out = 0;
        for (int c = 0; c < 20 && n_out < 4; c++) begin
            phv_valid_in = (n_in < 4);
            phv_in = stim[n_in < 4 ? n_in : 3];
            step();
            if (got_in) n_in++;
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== ek || got_phv !== ep || got_phv !== stim[n_out]) begin
                    bad++; $display("FAIL bp_order%0d: got=%h exp=%h", n_out, got_key, ek);
                end
                n_out++;
            end
        end
        phv_valid_in = 1'b0;
        total++; if (n_out != 4) begin bad++; $display("FAIL bp_timeout: got=%0d exp=4", n_out); end
    endtask

    task automatic test_cfg_collision();
        logic [KL-1:0] ek;
        logic [PL-1:0] ep;
        int n_out;
        wr_cfg(5, mk_cfg(0, 0, 0, 0, 0, 0, {2'b11, 18'h0}, '1));
        phv_ready_in = 1'b1;
        phv_valid_in = 1'b1;
        phv_in = rand_phv(5);
        step();
        phv_valid_in = 1'b0;
        // This write lands on the same edge the first PHV leaves S1
        cfg_wr_en = 1'b1;
        cfg_addr  = 4'd5;
        cfg_data  = mk_cfg(3, 2, 7, 6, 5, 4, {2'b10, 1'b1, 8'h00, 1'b0, 8'h18}, {96'h0, 97'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF});
        n_out = 0;
        for (int c = 0; c < 12 && n_out < 2; c++) begin
            step();
            cfg_wr_en = 1'b0;
            phv_valid_in = (c == 0);
            phv_in = rand_phv(5);
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== ek || got_phv !== ep) begin
                    bad++; $display("FAIL cfg_collision%0d: got=%h exp=%h", n_out, got_key, ek);
                end
                n_out++;
            end
        end
        phv_valid_in = 1'b0;
        total++; if (n_out != 2) begin bad++; $display("FAIL cfg_collision_timeout: got=%0d exp=2", n_out); end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] rc;
        logic [255:0]  rw;
        logic [KL-1:0] ek;
        logic [PL-1:0] ep;
        int n_in, n_out, cyc_in;
        for (int a = 0; a < 16; a++) begin
            for (int i = 0; i < 8; i++) rw[i*32 +: 32] = $urandom();
            rc = rw[CW-1:0];
            wr_cfg(a, rc);
        end
        n_in = 0;
        n_out = 0;
        cyc_in = 0;
        phv_ready_in = 1'b1;
        for (int c = 0; c < 200 && n_out < 24; c++) begin
            if (n_in >= 12) phv_ready_in = 1'($urandom_range(0, 1));
            phv_valid_in = (n_in < 12) ? 1'b1 : ((n_in < 24) ? 1'($urandom_range(0, 1)) : 1'b0);
            phv_in = rand_phv(int'($urandom_range(0, 15)));
            step();
            if (n_in < 12) cyc_in++;
            if (got_in) n_in++;
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== ek || got_phv !== ep) begin
                    bad++; $display("FAIL b2b_key%0d: got=%h exp=%h", n_out, got_key, ek);
                end
                n_out++;
            end
        end
        phv_valid_in = 1'b0;
        phv_ready_in = 1'b1;
        total++; if (cyc_in != 12) begin bad++; $display("FAIL b2b_throughput: got=%0d cycles exp=12", cyc_in); end
        total++; if (n_out != 24) begin bad++; $display("FAIL b2b_timeout: got=%0d exp=24", n_out); end
    endtask

    task automatic test_reset_midstream();
        logic [KL-1:0] ek;
        logic [PL-1:0] ep;
        int n_in, stale, n_out;
        phv_ready_in = 1'b0;
        n_in = 0;
        for (int c = 0; c < 6 && n_in < 2; c++) begin
            phv_valid_in = 1'b1;
            phv_in = rand_phv(5);
            step();
            if (got_in) n_in++;
        end
        phv_valid_in = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        total++; if (phv_valid_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got=%b exp=0", phv_valid_out); end
        total++; if (key_out !== '0) begin bad++; $display("FAIL midrst_key: got=%h exp=0", key_out); end
        exp_key_q.delete();
        exp_phv_q.delete();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        phv_ready_in = 1'b1;
        #1;
        total++; if (phv_ready_out !== 1'b1) begin bad++; $display("FAIL midrst_ready: got=%b exp=1", phv_ready_out); end
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (got_vout) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL midrst_stale: got=%0d exp=0", stale); end
        // Table was cleared as well: tenant 5 now yields a zero key
        phv_valid_in = 1'b1;
        phv_in = rand_phv(5);
        step();
        phv_valid_in = 1'b0;
        n_out = 0;
        for (int c = 0; c < 10 && n_out < 1; c++) begin
            step();
            if (got_out) begin
                total++;
                ek = exp_key_q.pop_front();
                ep = exp_phv_q.pop_front();
                if (got_key !== '0 || got_key !== ek || got_phv !== ep) begin
                    bad++; $display("FAIL midrst_table: got=%h exp=%h", got_key, ek);
                end
                n_out++;
            end
        end
        total++; if (n_out != 1) begin bad++; $display("FAIL midrst_timeout: got=%0d exp=1", n_out); end
    endtask

    initial begin
        rst          = 1'b1;
        phv_in       = '0;
        phv_valid_in = 1'b0;
        phv_ready_in = 1'b1;
        cfg_wr_en    = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_extract();
        test_compare();
        test_backpressure();
        test_cfg_collision();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
